// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and interrupt controller for a short in-order pipeline. It resolves
// taken branches (redirect and flush), holds fetch and decode for a number of
// cycles on a load-use hazard, holds fetch and decode while instruction memory
// is busy, and optionally vectors to an interrupt service routine.
//
// Optional feature: define PIPE_HAZARD_CTRL_IRQ_EN to build the interrupt
// logic (IRQ_VECTOR/ISR states and the epc register). Without the macro,
// irq_req and reti_d are ignored and branch_ISR, irq_ack, in_isr and epc
// are tied to 0.
//
// Parameters:
//   ISR_VECTOR        - ISR entry address driven on ISR_adr
//   LOAD_STALL_CYCLES - stall cycles per load-use hazard (1..7)
//
// Ports:
//   clock          - clock, rising edge
//   reset          - synchronous, active-high reset
//   branch_taken_e - branch resolved taken in execute
//   load_use_d     - decode reads the destination of the load in execute
//   mem_busy       - instruction memory not ready
//   irq_req        - level-sensitive interrupt request
//   reti_d         - return-from-interrupt in decode
//   pc_e           - PC of the execute-stage instruction
//   stall_f/d      - hold fetch / decode
//   flush_d/e      - flush decode / execute
//   PC_source      - select branch target as next PC
//   branch_ISR     - select ISR_adr as next PC
//   irq_ack        - interrupt acknowledge
//   in_isr         - interrupt service in progress
//   ISR_adr        - ISR entry address
//   epc            - captured return address
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter logic [11:0] ISR_VECTOR        = 12'h010,
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        branch_taken_e,
    input  logic        load_use_d,
    input  logic        mem_busy,
    input  logic        irq_req,
    input  logic        reti_d,
    input  logic [11:0] pc_e,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic        PC_source,
    output logic        branch_ISR,
    output logic        irq_ack,
    output logic        in_isr,
    output logic [11:0] ISR_adr,
    output logic [11:0] epc
);

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_STALL      = 2'd1;
`ifdef PIPE_HAZARD_CTRL_IRQ_EN
    localparam logic [1:0] ST_IRQ_VECTOR = 2'd2;
    localparam logic [1:0] ST_ISR        = 2'd3;
`endif

    // First stall cycle is spent in RUN/ISR, the rest are counted in STALL.
    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic       run_like;     // RUN or ISR: both accept branches and hazards
    logic [1:0] ret_state;    // state to resume after a stall
    logic       stall_int;
    logic       flush_int;
    logic       pc_src_int;
    logic       br_isr_int;
    logic       ack_int;
    logic       in_isr_int;

`ifdef PIPE_HAZARD_CTRL_IRQ_EN
    logic        ret_isr_q, ret_isr_d;  // stall was entered from ISR
    logic [11:0] epc_q, epc_d;

    assign run_like   = (state_q == ST_RUN) || (state_q == ST_ISR);
    assign ret_state  = ret_isr_q ? ST_ISR : ST_RUN;
    assign in_isr_int = (state_q == ST_ISR) || ((state_q == ST_STALL) && ret_isr_q);
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = irq_req ^ reti_d ^ (^pc_e);

    assign run_like   = (state_q == ST_RUN);
    assign ret_state  = ST_RUN;
    assign in_isr_int = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_int  = 1'b0;
        flush_int  = 1'b0;
        pc_src_int = 1'b0;
        br_isr_int = 1'b0;
        ack_int    = 1'b0;
`ifdef PIPE_HAZARD_CTRL_IRQ_EN
        ret_isr_d  = ret_isr_q;
        epc_d      = epc_q;
`endif

        if (run_like) begin
            if (branch_taken_e) begin
                // Branch beats a simultaneous load-use hazard.
                pc_src_int = 1'b1;
                flush_int  = 1'b1;
            end else if (load_use_d) begin
                stall_int = 1'b1;
                cnt_d     = STALL_RELOAD;
`ifdef PIPE_HAZARD_CTRL_IRQ_EN
                ret_isr_d = (state_q == ST_ISR);
`endif
                if (STALL_RELOAD != 3'd0) begin
                    state_d = ST_STALL;
                end
            end
`ifdef PIPE_HAZARD_CTRL_IRQ_EN
            else if (state_q == ST_RUN) begin
                if (irq_req && !mem_busy) begin
                    epc_d   = pc_e;
                    state_d = ST_IRQ_VECTOR;
                end
            end else if (reti_d) begin
                // reti only acts when decode is not held by a load-use hazard.
                state_d = ST_RUN;
            end
`endif
        end else if (state_q == ST_STALL) begin
            if (branch_taken_e) begin
                pc_src_int = 1'b1;
                flush_int  = 1'b1;
                cnt_d      = 3'd0;
                state_d    = ret_state;
            end else begin
                stall_int = 1'b1;
                cnt_d     = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = ret_state;
                end
            end
        end
`ifdef PIPE_HAZARD_CTRL_IRQ_EN
        else if (state_q == ST_IRQ_VECTOR) begin
            // Single vectoring cycle; branch and hazard inputs are ignored.
            flush_int  = 1'b1;
            br_isr_int = 1'b1;
            ack_int    = 1'b1;
            state_d    = ST_ISR;
        end
`endif
        else begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_HAZARD_CTRL_IRQ_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            ret_isr_q <= 1'b0;
            epc_q     <= 12'h000;
        end else begin
            ret_isr_q <= ret_isr_d;
            epc_q     <= epc_d;
        end
    end

    assign epc = epc_q;
`else
    assign epc = 12'h000;
`endif

    // Memory-busy stall is purely combinational; it never touches state.
    assign stall_f    = ~reset & (stall_int | mem_busy);
    assign stall_d    = ~reset & (stall_int | mem_busy);
    assign flush_d    = ~reset & flush_int;
    assign flush_e    = ~reset & flush_int;
    assign PC_source  = ~reset & pc_src_int;
    assign branch_ISR = ~reset & br_isr_int;
    assign irq_ack    = ~reset & ack_int;
    assign in_isr     = ~reset & in_isr_int;
    assign ISR_adr    = ISR_VECTOR;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        branch_taken_e = 1'b0;
    logic        load_use_d = 1'b0;
    logic        mem_busy = 1'b0;
    logic        irq_req = 1'b0;
    logic        reti_d = 1'b0;
    logic [11:0] pc_e = 12'h000;
    logic        stall_f, stall_d, flush_d, flush_e, PC_source, branch_ISR, irq_ack, in_isr;
    logic [11:0] ISR_adr, epc;

    pipe_hazard_ctrl #(
        .ISR_VECTOR        (12'h010),
        .LOAD_STALL_CYCLES (3)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .branch_taken_e (branch_taken_e),
        .load_use_d     (load_use_d),
        .mem_busy       (mem_busy),
        .irq_req        (irq_req),
        .reti_d         (reti_d),
        .pc_e           (pc_e),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .PC_source      (PC_source),
        .branch_ISR     (branch_ISR),
        .irq_ack        (irq_ack),
        .in_isr         (in_isr),
        .ISR_adr        (ISR_adr),
        .epc            (epc)
    );

    always #5 clock = ~clock;

    // Output vector: {stall_f, stall_d, flush_d, flush_e, PC_source, branch_ISR, irq_ack, in_isr}
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_STL  = 8'b1100_0000;
    localparam logic [7:0] O_BR   = 8'b0011_1000;
    localparam logic [7:0] O_VEC  = 8'b0011_0110;
    localparam logic [7:0] O_ISR  = 8'b0000_0001;

    // Input vector: {reset, branch_taken_e, load_use_d, mem_busy, irq_req, reti_d}
    localparam logic [5:0] I_NONE = 6'b000000;
    localparam logic [5:0] I_RST  = 6'b100000;
    localparam logic [5:0] I_BR   = 6'b010000;
    localparam logic [5:0] I_LU   = 6'b001000;
    localparam logic [5:0] I_MB   = 6'b000100;
    localparam logic [5:0] I_IRQ  = 6'b000010;
    localparam logic [5:0] I_RETI = 6'b000001;

    typedef struct {
        string       tag;
        logic [7:0]  outs;
        logic [11:0] epc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus just after the rising edge and queue what
    // the outputs must show during that cycle.
    task automatic drive(input string tag, input logic [5:0] in_bits, input logic [11:0] pc,
                         input logic [7:0] exp_o, input logic [11:0] exp_epc);
        exp_t e;
        @(posedge clock);
        #1;
        {reset, branch_taken_e, load_use_d, mem_busy, irq_req, reti_d} = in_bits;
        pc_e = pc;
        e.tag  = tag;
        e.outs = exp_o;
        e.epc  = exp_epc;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val({e.tag, ".outs"},
                      {24'h0, stall_f, stall_d, flush_d, flush_e, PC_source, branch_ISR,
                       irq_ack, in_isr}, {24'h0, e.outs});
            check_val({e.tag, ".epc"}, {20'h0, epc}, {20'h0, e.epc});
            check_val({e.tag, ".isr_adr"}, {20'h0, ISR_adr}, 32'h010);
        end
    end

    initial begin
        drive("rst_all",  I_RST | I_BR | I_LU | I_MB | I_IRQ, 12'h000, O_NONE, 12'h000);
        drive("rst",      I_RST,  12'h000, O_NONE, 12'h000);
        drive("idle",     I_NONE, 12'h000, O_NONE, 12'h000);
        drive("br",       I_BR,   12'h000, O_BR,   12'h000);
        drive("br_after", I_NONE, 12'h000, O_NONE, 12'h000);
        drive("lu_s1",    I_LU,   12'h000, O_STL,  12'h000);
        drive("lu_s2",    I_NONE, 12'h000, O_STL,  12'h000);
        drive("lu_s3",    I_NONE, 12'h000, O_STL,  12'h000);
        drive("lu_done",  I_NONE, 12'h000, O_NONE, 12'h000);
        drive("ab_s1",    I_LU,   12'h000, O_STL,  12'h000);
        drive("ab_br",    I_BR,   12'h000, O_BR,   12'h000);
        drive("ab_next",  I_NONE, 12'h000, O_NONE, 12'h000);
        drive("br_lu",    I_BR | I_LU, 12'h000, O_BR, 12'h000);
        drive("br_lu_nx", I_NONE, 12'h000, O_NONE, 12'h000);
        drive("mb",       I_MB,   12'h000, O_STL,  12'h000);
        drive("mb_next",  I_NONE, 12'h000, O_NONE, 12'h000);
        drive("mbs1",     I_LU,   12'h000, O_STL,  12'h000);
        drive("mbs2",     I_MB,   12'h000, O_STL,  12'h000);
        drive("mbs3",     I_NONE, 12'h000, O_STL,  12'h000);
        drive("mbs_done", I_NONE, 12'h000, O_NONE, 12'h000);
        drive("rs_s1",    I_LU,   12'h000, O_STL,  12'h000);
        drive("rs_rst",   I_RST,  12'h000, O_NONE, 12'h000);
        drive("rs_after", I_NONE, 12'h000, O_NONE, 12'h000);
        drive("rs_after2", I_NONE, 12'h000, O_NONE, 12'h000);
`ifdef PIPE_HAZARD_CTRL_IRQ_EN
        drive("irq_take", I_IRQ,  12'h123, O_NONE, 12'h000);
        drive("irq_vec",  I_BR | I_LU, 12'h456, O_VEC, 12'h123);
        drive("isr_hold", I_IRQ,  12'h456, O_ISR, 12'h123);
        drive("isr_br",   I_BR | I_IRQ, 12'h456, O_BR | O_ISR, 12'h123);
        drive("isr_lu",   I_LU,   12'h456, O_STL | O_ISR, 12'h123);
        drive("isr_s2",   I_NONE, 12'h456, O_STL | O_ISR, 12'h123);
        drive("isr_s3",   I_NONE, 12'h456, O_STL | O_ISR, 12'h123);
        drive("isr_back", I_NONE, 12'h456, O_ISR, 12'h123);
        drive("isr_reti", I_RETI, 12'h456, O_ISR, 12'h123);
        drive("isr_done", I_NONE, 12'h456, O_NONE, 12'h123);
        drive("pend_lu",  I_LU | I_IRQ, 12'h2AA, O_STL, 12'h123);
        drive("pend_s2",  I_IRQ,  12'h2AA, O_STL,  12'h123);
        drive("pend_s3",  I_IRQ,  12'h2AA, O_STL,  12'h123);
        drive("pend_take", I_IRQ, 12'h2AA, O_NONE, 12'h123);
        drive("pend_vec", I_NONE, 12'h2AA, O_VEC,  12'h2AA);
        drive("pend_isr", I_RETI, 12'h2AA, O_ISR,  12'h2AA);
        drive("pend_run", I_NONE, 12'h2AA, O_NONE, 12'h2AA);
        drive("rv_take",  I_IRQ,  12'h3C3, O_NONE, 12'h2AA);
        drive("rv_rst",   I_RST,  12'h3C3, O_NONE, 12'h3C3);
        drive("rv_after", I_NONE, 12'h3C3, O_NONE, 12'h000);
        drive("rv_after2", I_NONE, 12'h3C3, O_NONE, 12'h000);
`else
        drive("noirq1",   I_IRQ,  12'h123, O_NONE, 12'h000);
        drive("noirq2",   I_IRQ,  12'h123, O_NONE, 12'h000);
        drive("noirq3",   I_RETI, 12'h123, O_NONE, 12'h000);
        drive("noirq4",   I_NONE, 12'h123, O_NONE, 12'h000);
`endif
        repeat (2) @(posedge clock);
        check_val("drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter ISR_VECTOR, default 12'h010: interrupt service routine entry address driven on ISR_adr.
REQ-002 SHALL have parameter LOAD_STALL_CYCLES, default 1, legal range 1-7: number of fetch/decode stall cycles per load-use hazard.
REQ-003 SHALL have port clock, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port branch_taken_e, input, 1 bit: branch resolved taken in execute.
REQ-006 SHALL have port load_use_d, input, 1 bit: decode instruction reads the destination of the load in execute.
REQ-007 SHALL have port mem_busy, input, 1 bit: instruction memory not ready.
REQ-008 SHALL have port irq_req, input, 1 bit: level-sensitive interrupt request.
REQ-009 SHALL have port reti_d, input, 1 bit: return-from-interrupt in decode.
REQ-010 SHALL have port pc_e, input, 12 bits: PC of the execute-stage instruction.
REQ-011 SHALL have outputs stall_f, stall_d, flush_d, flush_e, PC_source, branch_ISR, irq_ack and in_isr, each 1 bit: fetch-stage controls, interrupt acknowledge and in-service flag.
REQ-012 SHALL have output ISR_adr, 12 bits, equal to ISR_VECTOR.
REQ-013 SHALL have output epc, 12 bits: registered return address.

Function
REQ-014 SHALL implement states RUN, STALL, IRQ_VECTOR and ISR, held in a registered state variable.
REQ-015 In RUN/ISR, branch_taken_e=1 SHALL combinationally drive PC_source=1, flush_d=1 and flush_e=1 in the same cycle, with no state change.
REQ-016 In RUN/ISR, load_use_d=1 with branch_taken_e=0 SHALL assert stall_f=stall_d=1 that cycle, load a counter with LOAD_STALL_CYCLES-1 and enter STALL if the counter is nonzero.
REQ-017 In STALL, the block SHALL assert stall_f=stall_d=1 and decrement the counter, returning to the originating state (RUN or ISR) on the cycle the counter reaches 0.
REQ-018 branch_taken_e in STALL SHALL abort the stall: apply the REQ-015 outputs, deassert the stall outputs, clear the counter and return to the originating state next cycle.
REQ-019 When branch_taken_e and load_use_d are both high, branch SHALL win, with no stall asserted.
REQ-020 mem_busy=1 SHALL force stall_f=1 and stall_d=1 in any state without altering state or counter.
REQ-021 In RUN, irq_req=1 with branch_taken_e=0, load_use_d=0, mem_busy=0 SHALL capture epc<=pc_e and enter IRQ_VECTOR next cycle.
REQ-022 irq_req arriving in STALL SHALL remain pending until RUN is re-entered.
REQ-023 In IRQ_VECTOR (exactly one cycle), the block SHALL assert branch_ISR=1, flush_d=1, flush_e=1 and irq_ack=1, ignore branch_taken_e and load_use_d, then enter ISR.
REQ-024 In ISR, in_isr SHALL be 1 and irq_req SHALL be ignored (no nesting).
REQ-025 reti_d=1 in ISR with branch_taken_e=0 SHALL return to RUN next cycle, with in_isr deasserted from that cycle.
REQ-026 epc SHALL hold its value until the next interrupt acceptance.
REQ-027 Outputs not asserted by a rule above SHALL be 0.

Reset
REQ-028 reset=1 at a clock edge SHALL set state=RUN, counter=0, epc=0, in_isr=0, overriding every other input, including mid-STALL and mid-IRQ_VECTOR.
REQ-029 While reset=1, all 1-bit outputs SHALL be 0 and ISR_adr SHALL remain ISR_VECTOR.

Configuration
REQ-030 With macro PIPE_HAZARD_CTRL_IRQ_EN defined, REQ-021 to REQ-026 SHALL apply.
REQ-031 With PIPE_HAZARD_CTRL_IRQ_EN undefined, IRQ_VECTOR/ISR logic and the epc register SHALL be absent, branch_ISR=irq_ack=in_isr=0, epc=0, and irq_req/reti_d SHALL be ignored.

Verification
REQ-032 Branch: branch_taken_e=1 for 1 cycle in RUN -> PC_source=flush_d=flush_e=1 that cycle only, state stays RUN.
REQ-033 Load-use: LOAD_STALL_CYCLES=3, load_use_d pulse 1 cycle -> stall_f=stall_d=1 for exactly 3 cycles, then 0.
REQ-034 Abort: branch_taken_e in the 2nd stall cycle -> flush asserted, stall_f=0 next cycle.
REQ-035 Interrupt: pc_e=12'h123, irq_req=1 in RUN -> next cycle branch_ISR=irq_ack=1, ISR_adr=12'h010; epc=12'h123; in_isr=1 until the cycle after reti_d.
REQ-036 Reset in IRQ_VECTOR -> next cycle all 1-bit outputs 0, epc=0; with macro undefined, irq_req never raises branch_ISR.
